panel_frame_writer: RTL and testbench

- Upstream stage of the LED panel display driver, in the ctrl_clk domain.
- Accepts a 24-bit RGB pixel stream (valid/ready, start-of-frame marker) in raster order and reduces each colour byte to INPUT_DEPTH bits.
- Generates the write strobes, write enables, addresses and data for the panel's video memory: ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat.
- Also provides a hardware screen fill (clear to a constant colour) and frame status/error reporting.

---
 rtl/panel_frame_writer_pkg.sv | 31 +++
 rtl/panel_frame_writer_if.sv | 19 +
 rtl/panel_frame_writer_color_reduce.sv | 25 ++
 rtl/panel_frame_writer.sv | 196 +++++++++++++++++++
 tb/tb_panel_frame_writer.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/panel_frame_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : panel_pkg
// Brief    : Shared geometry, channel write-enable codes and FSM states for
//            the panel frame writer.
// Revision : 1.0
// ============================================================================
package panel_pkg;

    localparam int PANEL_W = 64;
    localparam int PANEL_H = 64;
    localparam int PIXEL_W = 24;

    localparam logic [3:0] WR_R   = 4'b0100;
    localparam logic [3:0] WR_G   = 4'b0010;
    localparam logic [3:0] WR_B   = 4'b0001;
    localparam logic [3:0] WR_RGB = 4'b0111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FILL   = 2'd2
    } state_t;

    // Address bits needed for one chain: 6 bits of y, 6+clog2(CHAINED) of x.
    function automatic int addr_width(input int chained);
        return 12 + $clog2(chained);
    endfunction

endpackage
`default_nettype wire

// File: rtl/panel_frame_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : panel_frame_writer_if
// Brief    : Raster-order RGB pixel stream with valid/ready and SOF marker.
// Revision : 1.0
// ============================================================================
interface panel_frame_writer_if;
    import panel_pkg::*;

    logic               s_valid;
    logic               s_ready;
    logic               s_sof;
    logic [PIXEL_W-1:0] s_data;

    modport master (output s_valid, output s_sof, output s_data, input  s_ready);
    modport slave  (input  s_valid, input  s_sof, input  s_data, output s_ready);

endinterface
`default_nettype wire

// File: rtl/panel_frame_writer_color_reduce.sv
`default_nettype none
// ============================================================================
// Module   : panel_color_reduce
// Brief    : Truncates each 8-bit colour to INPUT_DEPTH bits, right-justified
//            in its byte with the upper bits zero.
// Revision : 1.0
// ============================================================================
module panel_color_reduce
    import panel_pkg::*;
#(
    parameter int INPUT_DEPTH = 6
) (
    input  logic [PIXEL_W-1:0] i_rgb,
    output logic [PIXEL_W-1:0] o_rgb
);

    genvar i;
    generate
        for (i = 0; i < 3; i++) begin : g_chan
            assign o_rgb[8*i +: 8] = i_rgb[8*i +: 8] >> (8 - INPUT_DEPTH);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/panel_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : panel_frame_writer
// Brief    : Converts a raster RGB stream into panel video-memory writes, with
//            a hardware screen fill and frame status reporting.
// Revision : 1.0
// ============================================================================
module panel_frame_writer
    import panel_pkg::*;
#(
    parameter int INPUT_DEPTH = 6,
    parameter int CHAINED     = 2
) (
    input  logic                ctrl_clk,
    input  logic                ctrl_resetn,
    panel_frame_writer_if.slave pix,
    input  logic                fill_start,
    input  logic [PIXEL_W-1:0]  fill_color,
    output logic                ctrl_en,
    output logic [3:0]          ctrl_wr,
    output logic [15:0]         ctrl_addr,
    output logic [PIXEL_W-1:0]  ctrl_wdat,
    output logic                busy,
    output logic                frame_done,
    output logic                frame_err
);

    localparam int               c_SIZE_BITS = $clog2(CHAINED);
    localparam int               c_XW        = 6 + c_SIZE_BITS;
    localparam int               c_AW        = addr_width(CHAINED);
    localparam int               c_PIXELS    = PANEL_W * PANEL_H * CHAINED;
    localparam logic [c_XW-1:0]  c_X_MAX     = c_XW'(PANEL_W * CHAINED - 1);
    localparam logic [5:0]       c_Y_MAX     = 6'(PANEL_H - 1);
    localparam logic [c_AW:0]    c_FILL_END  = (c_AW+1)'(c_PIXELS);

    state_t               r_state,     w_state_nxt;
    logic [c_XW-1:0]      r_x,         w_x_nxt;
    logic [5:0]           r_y,         w_y_nxt;
    logic [c_AW:0]        r_fill_addr, w_fill_addr_nxt;
    logic [PIXEL_W-1:0]   r_fill_wdat, w_fill_wdat_nxt;
    logic                 r_err,       w_err_nxt;
    logic                 r_en,        w_en_nxt;
    logic [3:0]           r_wr,        w_wr_nxt;
    logic [15:0]          r_addr,      w_addr_nxt;
    logic [PIXEL_W-1:0]   r_wdat,      w_wdat_nxt;
    logic                 r_done,      w_done_nxt;

    logic [PIXEL_W-1:0]   w_pix_rgb;
    logic [PIXEL_W-1:0]   w_fill_rgb;
    logic                 w_ready;
    logic                 w_accept;
    logic [15:0]          w_pix_addr;
    logic [15:0]          w_fill_addr;

    panel_color_reduce #(.INPUT_DEPTH(INPUT_DEPTH)) u_reduce_pix (
        .i_rgb (pix.s_data),
        .o_rgb (w_pix_rgb)
    );

    panel_color_reduce #(.INPUT_DEPTH(INPUT_DEPTH)) u_reduce_fill (
        .i_rgb (fill_color),
        .o_rgb (w_fill_rgb)
    );

    // A same-cycle fill request wins over the pixel beat.
    assign w_ready     = (r_state != FILL) && !fill_start;
    assign pix.s_ready = w_ready;
    assign w_accept    = pix.s_valid && w_ready;
    assign w_pix_addr  = 16'({r_y, r_x});
    assign w_fill_addr = 16'(r_fill_addr[c_AW-1:0]);

    always_comb begin
        w_state_nxt     = r_state;
        w_x_nxt         = r_x;
        w_y_nxt         = r_y;
        w_fill_addr_nxt = r_fill_addr;
        w_fill_wdat_nxt = r_fill_wdat;
        w_err_nxt       = r_err;
        w_en_nxt        = 1'b0;
        w_wr_nxt        = 4'b0000;
        w_addr_nxt      = r_addr;
        w_wdat_nxt      = r_wdat;
        w_done_nxt      = 1'b0;

        if (fill_start && (r_state != FILL)) begin
            // Address 0 is written on the request edge so the fill spans
            // exactly the cycles in which busy is high.
            w_state_nxt     = FILL;
            w_x_nxt         = '0;
            w_y_nxt         = '0;
            w_fill_wdat_nxt = w_fill_rgb;
            w_fill_addr_nxt = (c_AW+1)'(1);
            w_en_nxt        = 1'b1;
            w_wr_nxt        = WR_RGB;
            w_addr_nxt      = '0;
            w_wdat_nxt      = w_fill_rgb;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (pix.s_sof) begin
                            w_state_nxt = STREAM;
                            w_err_nxt   = 1'b0;
                            w_x_nxt     = c_XW'(1);
                            w_y_nxt     = '0;
                            w_en_nxt    = 1'b1;
                            w_wr_nxt    = WR_RGB;
                            w_addr_nxt  = '0;
                            w_wdat_nxt  = w_pix_rgb;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (w_accept) begin
                        w_en_nxt   = 1'b1;
                        w_wr_nxt   = WR_RGB;
                        w_wdat_nxt = w_pix_rgb;
                        if (pix.s_sof) begin
                            w_err_nxt  = 1'b1;
                            w_addr_nxt = '0;
                            w_x_nxt    = c_XW'(1);
                            w_y_nxt    = '0;
                        end else begin
                            w_addr_nxt = w_pix_addr;
                            if (r_x == c_X_MAX) begin
                                w_x_nxt = '0;
                                if (r_y == c_Y_MAX) begin
                                    w_y_nxt     = '0;
                                    w_done_nxt  = 1'b1;
                                    w_state_nxt = IDLE;
                                end else begin
                                    w_y_nxt = r_y + 6'd1;
                                end
                            end else begin
                                w_x_nxt = r_x + c_XW'(1);
                            end
                        end
                    end
                end
                FILL: begin
                    if (r_fill_addr == c_FILL_END) begin
                        w_state_nxt     = IDLE;
                        w_fill_addr_nxt = '0;
                    end else begin
                        w_en_nxt        = 1'b1;
                        w_wr_nxt        = WR_RGB;
                        w_addr_nxt      = w_fill_addr;
                        w_wdat_nxt      = r_fill_wdat;
                        w_fill_addr_nxt = r_fill_addr + (c_AW+1)'(1);
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge ctrl_clk or negedge ctrl_resetn) begin
        if (!ctrl_resetn) begin
            r_state     <= IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_fill_addr <= '0;
            r_fill_wdat <= '0;
            r_err       <= 1'b0;
            r_en        <= 1'b0;
            r_wr        <= 4'b0000;
            r_addr      <= '0;
            r_wdat      <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_x         <= w_x_nxt;
            r_y         <= w_y_nxt;
            r_fill_addr <= w_fill_addr_nxt;
            r_fill_wdat <= w_fill_wdat_nxt;
            r_err       <= w_err_nxt;
            r_en        <= w_en_nxt;
            r_wr        <= w_wr_nxt;
            r_addr      <= w_addr_nxt;
            r_wdat      <= w_wdat_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign ctrl_en    = r_en;
    assign ctrl_wr    = r_wr;
    assign ctrl_addr  = r_addr;
    assign ctrl_wdat  = r_wdat;
    assign busy       = (r_state == FILL);
    assign frame_done = r_done;
    assign frame_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_panel_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_panel_frame_writer
// Brief    : Self-checking bench: vector table, randomized stream against a
//            pixel-index reference model, fill and reset corner cases.
// Revision : 1.0
// ============================================================================
module tb_panel_frame_writer;

    localparam int INPUT_DEPTH = 6;
    localparam int CHAINED     = 2;
    localparam int W           = 64 * CHAINED;
    localparam int N           = W * 64;
    localparam int XW          = 6 + $clog2(CHAINED);

    logic        ctrl_clk = 1'b0;
    logic        ctrl_resetn;
    logic        fill_start;
    logic [23:0] fill_color;
    logic        ctrl_en;
    logic [3:0]  ctrl_wr;
    logic [15:0] ctrl_addr;
    logic [23:0] ctrl_wdat;
    logic        busy;
    logic        frame_done;
    logic        frame_err;

    panel_frame_writer_if pix ();

    panel_frame_writer #(.INPUT_DEPTH(INPUT_DEPTH), .CHAINED(CHAINED)) dut (
        .ctrl_clk    (ctrl_clk),
        .ctrl_resetn (ctrl_resetn),
        .pix         (pix),
        .fill_start  (fill_start),
        .fill_color  (fill_color),
        .ctrl_en     (ctrl_en),
        .ctrl_wr     (ctrl_wr),
        .ctrl_addr   (ctrl_addr),
        .ctrl_wdat   (ctrl_wdat),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_err   (frame_err)
    );

    always #5 ctrl_clk = ~ctrl_clk;

    typedef struct {
        logic [15:0] addr;
        logic [23:0] wdat;
        logic        done;
    } wr_t;

    typedef struct {
        logic        sof;
        logic [23:0] data;
        logic        exp_en;
        logic [15:0] exp_addr;
        logic [23:0] exp_wdat;
        logic        exp_err;
    } vec_t;

    wr_t exp_q[$];
    int  n_tests     = 0;
    int  n_fail      = 0;
    int  n_done_seen = 0;
    int  m_done_exp  = 0;
    int  m_k         = 0;
    bit  m_in_frame  = 1'b0;
    bit  m_err       = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: pixel position is a linear raster index.
    function automatic logic [23:0] ref_reduce(input logic [23:0] c);
        int          scale;
        logic [23:0] r;
        scale = 1 << (8 - INPUT_DEPTH);
        r     = '0;
        for (int b = 0; b < 3; b++)
            r[8*b +: 8] = 8'(int'((c >> (8*b)) & 24'hFF) / scale);
        return r;
    endfunction

    function automatic logic [15:0] ref_addr(input int k);
        return 16'(((k / W) << XW) + (k % W));
    endfunction

    task automatic push_wr(input logic [15:0] a, input logic [23:0] d, input logic dn);
        wr_t e;
        e.addr = a; e.wdat = d; e.done = dn;
        exp_q.push_back(e);
    endtask

    task automatic model_beat(input logic sof, input logic [23:0] data);
        if (sof) begin
            m_err      = m_in_frame;
            push_wr(16'h0, ref_reduce(data), 1'b0);
            m_k        = 1;
            m_in_frame = 1'b1;
        end else if (!m_in_frame) begin
            m_err = 1'b1;
        end else begin
            push_wr(ref_addr(m_k), ref_reduce(data), m_k == N - 1);
            if (m_k == N - 1) begin
                m_done_exp++;
                m_in_frame = 1'b0;
                m_k        = 0;
            end else begin
                m_k++;
            end
        end
    endtask

    task automatic model_fill(input logic [23:0] color);
        for (int i = 0; i < N; i++) push_wr(16'(i), ref_reduce(color), 1'b0);
        m_in_frame = 1'b0;
        m_k        = 0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_in_frame = 1'b0;
        m_k        = 0;
        m_err      = 1'b0;
    endtask

    always @(negedge ctrl_clk) begin
        if (ctrl_en) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0h wdat %0h, expected no write", ctrl_addr, ctrl_wdat);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write", {ctrl_wr, ctrl_addr, ctrl_wdat, frame_done}, {4'h7, e.addr, e.wdat, e.done});
            end
            if (frame_done) n_done_seen++;
        end else begin
            check("stray_done", frame_done, 1'b0);
        end
    end

    // All tasks below start and end 1 time unit after a rising edge.
    task automatic send_beat(input logic sof, input logic [23:0] data);
        logic acc;
        pix.s_valid = 1'b1;
        pix.s_sof   = sof;
        pix.s_data  = data;
        @(negedge ctrl_clk);
        acc = pix.s_ready;
        @(posedge ctrl_clk); #1;
        pix.s_valid = 1'b0;
        if (acc) model_beat(sof, data);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            pix.s_valid = 1'b0;
            pix.s_sof   = 1'($urandom_range(0, 1));
            pix.s_data  = 24'($urandom);
            @(posedge ctrl_clk); #1;
        end
    endtask

    task automatic apply_reset();
        ctrl_resetn = 1'b0;
        pix.s_valid = 1'b0;
        fill_start  = 1'b0;
        model_reset();
        repeat (3) @(posedge ctrl_clk);
        #1;
        check("reset_outputs", {ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat, busy, frame_done, frame_err}, '0);
        check("reset_ready", pix.s_ready, 1'b1);
        ctrl_resetn = 1'b1;
        @(posedge ctrl_clk); #1;
    endtask

    vec_t vecs[10];

    initial begin
        int done0;
        int cnt;
        int bad;

        pix.s_valid = 1'b0;
        pix.s_sof   = 1'b0;
        pix.s_data  = '0;
        fill_start  = 1'b0;
        fill_color  = '0;
        ctrl_resetn = 1'b1;
        #1;
        apply_reset();

        // Drops before SOF, colour reduction, short frame restart.
        vecs[0] = '{1'b0, 24'h123456, 1'b0, 16'h0000, 24'h000000, 1'b1};
        vecs[1] = '{1'b0, 24'hABCDEF, 1'b0, 16'h0000, 24'h000000, 1'b1};
        vecs[2] = '{1'b0, 24'h010203, 1'b0, 16'h0000, 24'h000000, 1'b1};
        vecs[3] = '{1'b1, 24'hFF8001, 1'b1, 16'h0000, 24'h3F2000, 1'b0};
        vecs[4] = '{1'b0, 24'h808080, 1'b1, 16'h0001, 24'h202020, 1'b0};
        vecs[5] = '{1'b0, 24'hFFFFFF, 1'b1, 16'h0002, 24'h3F3F3F, 1'b0};
        vecs[6] = '{1'b0, 24'h03FC04, 1'b1, 16'h0003, 24'h003F01, 1'b0};
        vecs[7] = '{1'b0, 24'h7F4081, 1'b1, 16'h0004, 24'h1F1020, 1'b0};
        vecs[8] = '{1'b1, 24'h000000, 1'b1, 16'h0000, 24'h000000, 1'b1};
        vecs[9] = '{1'b0, 24'h0C0C0C, 1'b1, 16'h0001, 24'h030303, 1'b1};
        for (int i = 0; i < 10; i++) begin
            send_beat(vecs[i].sof, vecs[i].data);
            check($sformatf("vec%0d_en", i), ctrl_en, vecs[i].exp_en);
            check($sformatf("vec%0d_wr", i), ctrl_wr, vecs[i].exp_en ? 4'h7 : 4'h0);
            if (vecs[i].exp_en) begin
                check($sformatf("vec%0d_addr", i), ctrl_addr, vecs[i].exp_addr);
                check($sformatf("vec%0d_wdat", i), ctrl_wdat, vecs[i].exp_wdat);
            end
            check($sformatf("vec%0d_err", i), frame_err, vecs[i].exp_err);
            check($sformatf("vec%0d_done", i), frame_done, 1'b0);
        end

        // Full frame with random data and random gaps.
        apply_reset();
        done0 = n_done_seen;
        send_beat(1'b1, 24'($urandom));
        for (int k = 1; k < N; k++) begin
            if ($urandom_range(0, 7) == 0) idle_cycles($urandom_range(1, 3));
            send_beat(1'b0, 24'($urandom));
        end
        idle_cycles(2);
        check("full_frame_done_count", n_done_seen - done0, 1);
        check("full_frame_err", frame_err, 1'b0);
        check("full_frame_pending", exp_q.size(), 0);

        send_beat(1'b0, 24'($urandom));
        check("idle_drop_en", ctrl_en, 1'b0);
        check("idle_drop_err", frame_err, 1'b1);

        // Mixed random stream with occasional SOF markers.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
            send_beat($urandom_range(0, 49) == 0, 24'($urandom));
            check("mixed_err", frame_err, m_err);
        end
        idle_cycles(2);
        check("mixed_done_count", n_done_seen, m_done_exp);
        check("mixed_pending", exp_q.size(), 0);

        // Fill requested mid-frame with a colliding pixel beat.
        send_beat(1'b1, 24'($urandom));
        for (int i = 0; i < 37; i++) send_beat(1'b0, 24'($urandom));
        done0       = n_done_seen;
        fill_start  = 1'b1;
        fill_color  = 24'h0040FF;
        pix.s_valid = 1'b1;
        pix.s_sof   = 1'b0;
        pix.s_data  = 24'($urandom);
        @(negedge ctrl_clk);
        check("fill_collide_ready", pix.s_ready, 1'b0);
        @(posedge ctrl_clk); #1;
        fill_start  = 1'b0;
        pix.s_valid = 1'b0;
        model_fill(24'h0040FF);
        check("fill_first_write", {ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat}, {1'b1, 4'h7, 16'h0000, 24'h00103F});
        cnt = 0;
        while (busy && cnt < N + 100) begin
            cnt++;
            fill_start = (cnt == 50);
            fill_color = 24'($urandom);
            if (pix.s_ready) bad = 1;
            @(posedge ctrl_clk); #1;
        end
        fill_start = 1'b0;
        check("fill_busy_cycles", cnt, N);
        check("fill_busy_low", busy, 1'b0);
        check("fill_ready_after", pix.s_ready, 1'b1);
        idle_cycles(1);
        check("fill_pending", exp_q.size(), 0);
        check("fill_no_done", n_done_seen - done0, 0);
        send_beat(1'b0, 24'($urandom));
        check("after_fill_drop_en", ctrl_en, 1'b0);
        check("after_fill_err", frame_err, 1'b1);
        send_beat(1'b1, 24'hFF8001);
        check("after_fill_sof", {ctrl_en, ctrl_addr, ctrl_wdat, frame_err}, {1'b1, 16'h0000, 24'h3F2000, 1'b0});

        // Reset asserted in the middle of a fill.
        fill_start = 1'b1;
        fill_color = 24'($urandom);
        @(posedge ctrl_clk); #1;
        fill_start = 1'b0;
        model_fill(fill_color);
        cnt = 0;
        while (!(ctrl_en && ctrl_addr == 16'h0100) && cnt < 2000) begin
            cnt++;
            @(posedge ctrl_clk); #1;
        end
        if (cnt >= 2000) begin
            n_tests++;
            n_fail++;
            $display("FAIL fill_reach_0100: timeout after %0d cycles, addr %0h", cnt, ctrl_addr);
        end
        #2;
        ctrl_resetn = 1'b0;
        model_reset();
        #1;
        check("async_reset_en", ctrl_en, 1'b0);
        check("async_reset_busy", busy, 1'b0);
        check("async_reset_bus", {ctrl_wr, ctrl_addr, ctrl_wdat}, '0);
        repeat (2) @(posedge ctrl_clk);
        #1;
        ctrl_resetn = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (ctrl_en || busy) bad++;
            @(posedge ctrl_clk); #1;
        end
        check("post_reset_quiet", bad, 0);
        send_beat(1'b1, 24'hFF8001);
        check("post_reset_sof", {ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat}, {1'b1, 4'h7, 16'h0000, 24'h3F2000});
        idle_cycles(2);
        check("final_pending", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
